// File: rtl/pipe_alu_pkg.sv
// Shared opcode encodings and widths for the forwarding ALU pipeline.
package pipe_alu_pkg;

    localparam int unsigned FUNC_W = 4;

    localparam logic [FUNC_W-1:0] OP_ADD     = 4'd0;
    localparam logic [FUNC_W-1:0] OP_SUB     = 4'd1;
    localparam logic [FUNC_W-1:0] OP_MUL     = 4'd2;
    localparam logic [FUNC_W-1:0] OP_PASSA   = 4'd3;
    localparam logic [FUNC_W-1:0] OP_PASSB   = 4'd4;
    localparam logic [FUNC_W-1:0] OP_AND     = 4'd5;
    localparam logic [FUNC_W-1:0] OP_OR      = 4'd6;
    localparam logic [FUNC_W-1:0] OP_XOR     = 4'd7;
    localparam logic [FUNC_W-1:0] OP_NOTA    = 4'd8;
    localparam logic [FUNC_W-1:0] OP_NOTB    = 4'd9;
    localparam logic [FUNC_W-1:0] OP_SRL     = 4'd10;
    localparam logic [FUNC_W-1:0] OP_SLL     = 4'd11;
    localparam logic [FUNC_W-1:0] OP_LDI     = 4'd12;
    localparam logic [FUNC_W-1:0] OP_ILL_MIN = 4'd13;

endpackage

// File: rtl/pipe_alu_core.sv
// Combinational ALU: result, carry/borrow/overflow flag and illegal-opcode flag.
module pipe_alu_core
    import pipe_alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [IMM_W-1:0]  imm_i,
    input  logic [FUNC_W-1:0] func_i,
    output logic [DATA_W-1:0] z_o,
    output logic              c_o,
    output logic              ill_o
);

    localparam int unsigned EW = DATA_W + 1;
    localparam int unsigned PW = 2 * DATA_W;

    logic [EW-1:0] sum;
    logic [EW-1:0] diff;
    logic [PW-1:0] prod;

    // Extended-width arithmetic so the flag falls out of the top bit(s).
    always_comb begin
        sum  = {1'b0, a_i} + {1'b0, b_i};
        diff = {1'b0, a_i} - {1'b0, b_i};
        prod = PW'(a_i) * PW'(b_i);
    end

    // Opcode decode; codes at or above OP_ILL_MIN fall to the illegal default.
    always_comb begin
        z_o   = '0;
        c_o   = 1'b0;
        ill_o = 1'b0;
        case (func_i)
            OP_ADD:   begin z_o = sum[DATA_W-1:0];  c_o = sum[DATA_W];  end
            OP_SUB:   begin z_o = diff[DATA_W-1:0]; c_o = diff[DATA_W]; end
            OP_MUL:   begin z_o = prod[DATA_W-1:0]; c_o = |prod[PW-1:DATA_W]; end
            OP_PASSA: z_o = a_i;
            OP_PASSB: z_o = b_i;
            OP_AND:   z_o = a_i & b_i;
            OP_OR:    z_o = a_i | b_i;
            OP_XOR:   z_o = a_i ^ b_i;
            OP_NOTA:  z_o = ~a_i;
            OP_NOTB:  z_o = ~b_i;
            OP_SRL:   begin z_o = {1'b0, a_i[DATA_W-1:1]}; c_o = a_i[0]; end
            OP_SLL:   begin z_o = {a_i[DATA_W-2:0], 1'b0}; c_o = a_i[DATA_W-1]; end
            OP_LDI:   z_o = DATA_W'(imm_i);
            default:  ill_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_alu_fwd.sv
// 4-stage RD -> EX -> WB -> MW register-to-memory ALU pipeline with full RAW forwarding.
module pipe_alu_fwd
    import pipe_alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [FUNC_W-1:0] func,
    input  logic [MEM_AW-1:0] addr,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_z,
    output logic [MEM_AW-1:0] out_addr,
    output logic              out_c,
    output logic              out_zero,
    output logic              out_ill,
    input  logic [MEM_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned NREG = 1 << REG_AW;
    localparam int unsigned NMEM = 1 << MEM_AW;

    // Read stage
    logic              rds_valid_q, rds_valid_d;
    logic [DATA_W-1:0] rds_a_q, rds_a_d;
    logic [DATA_W-1:0] rds_b_q, rds_b_d;
    logic [REG_AW-1:0] rds_rs1_q, rds_rs1_d;
    logic [REG_AW-1:0] rds_rs2_q, rds_rs2_d;
    logic [REG_AW-1:0] rds_rd_q, rds_rd_d;
    logic [FUNC_W-1:0] rds_func_q, rds_func_d;
    logic [MEM_AW-1:0] rds_addr_q, rds_addr_d;

    // Execute stage
    logic              exs_valid_q, exs_valid_d;
    logic [REG_AW-1:0] exs_rd_q, exs_rd_d;
    logic [DATA_W-1:0] exs_z_q, exs_z_d;
    logic              exs_c_q, exs_c_d;
    logic              exs_ill_q, exs_ill_d;
    logic [MEM_AW-1:0] exs_addr_q, exs_addr_d;

    // Write-back stage
    logic              wbs_valid_q, wbs_valid_d;
    logic [DATA_W-1:0] wbs_z_q, wbs_z_d;
    logic              wbs_c_q, wbs_c_d;
    logic              wbs_zero_q, wbs_zero_d;
    logic              wbs_ill_q, wbs_ill_d;
    logic [MEM_AW-1:0] wbs_addr_q, wbs_addr_d;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] mem_q  [NMEM];

    logic              exs_fwd_ok;
    logic [DATA_W-1:0] alu_a, alu_b, alu_z;
    logic              alu_c, alu_ill;

    // EX-latched result is a legal forwarding source only for a valid, legal op.
    always_comb begin
        exs_fwd_ok = exs_valid_q && !exs_ill_q;
        alu_a = (exs_fwd_ok && (exs_rd_q == rds_rs1_q)) ? exs_z_q : rds_a_q;
        alu_b = (exs_fwd_ok && (exs_rd_q == rds_rs2_q)) ? exs_z_q : rds_b_q;
    end

    pipe_alu_core #(
        .DATA_W (DATA_W),
        .IMM_W  (MEM_AW)
    ) u_core (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .imm_i  (rds_addr_q),
        .func_i (rds_func_q),
        .z_o    (alu_z),
        .c_o    (alu_c),
        .ill_o  (alu_ill)
    );

    // Next-state for all stages; capture bypasses the regbank write happening this edge.
    always_comb begin
        rds_valid_d = in_valid && !flush;
        rds_a_d     = (exs_fwd_ok && (exs_rd_q == rs1)) ? exs_z_q : regs_q[rs1];
        rds_b_d     = (exs_fwd_ok && (exs_rd_q == rs2)) ? exs_z_q : regs_q[rs2];
        rds_rs1_d   = rs1;
        rds_rs2_d   = rs2;
        rds_rd_d    = rd;
        rds_func_d  = func;
        rds_addr_d  = addr;

        exs_valid_d = rds_valid_q && !flush;
        exs_rd_d    = rds_rd_q;
        exs_z_d     = alu_z;
        exs_c_d     = alu_c;
        exs_ill_d   = alu_ill;
        exs_addr_d  = rds_addr_q;

        wbs_valid_d = exs_valid_q && !flush;
        wbs_z_d     = exs_z_q;
        wbs_c_d     = exs_c_q;
        wbs_zero_d  = (exs_z_q == DATA_W'(0));
        wbs_ill_d   = exs_ill_q;
        wbs_addr_d  = exs_addr_q;
    end

    // Stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rds_valid_q <= 1'b0;
            rds_a_q     <= '0;
            rds_b_q     <= '0;
            rds_rs1_q   <= '0;
            rds_rs2_q   <= '0;
            rds_rd_q    <= '0;
            rds_func_q  <= '0;
            rds_addr_q  <= '0;
            exs_valid_q <= 1'b0;
            exs_rd_q    <= '0;
            exs_z_q     <= '0;
            exs_c_q     <= 1'b0;
            exs_ill_q   <= 1'b0;
            exs_addr_q  <= '0;
            wbs_valid_q <= 1'b0;
            wbs_z_q     <= '0;
            wbs_c_q     <= 1'b0;
            wbs_zero_q  <= 1'b0;
            wbs_ill_q   <= 1'b0;
            wbs_addr_q  <= '0;
        end else begin
            rds_valid_q <= rds_valid_d;
            rds_a_q     <= rds_a_d;
            rds_b_q     <= rds_b_d;
            rds_rs1_q   <= rds_rs1_d;
            rds_rs2_q   <= rds_rs2_d;
            rds_rd_q    <= rds_rd_d;
            rds_func_q  <= rds_func_d;
            rds_addr_q  <= rds_addr_d;
            exs_valid_q <= exs_valid_d;
            exs_rd_q    <= exs_rd_d;
            exs_z_q     <= exs_z_d;
            exs_c_q     <= exs_c_d;
            exs_ill_q   <= exs_ill_d;
            exs_addr_q  <= exs_addr_d;
            wbs_valid_q <= wbs_valid_d;
            wbs_z_q     <= wbs_z_d;
            wbs_c_q     <= wbs_c_d;
            wbs_zero_q  <= wbs_zero_d;
            wbs_ill_q   <= wbs_ill_d;
            wbs_addr_q  <= wbs_addr_d;
        end
    end

    // Register bank: cleared on reset, written from the EX stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (exs_fwd_ok) begin
            regs_q[exs_rd_q] <= exs_z_q;
        end
    end

    // Data memory: no reset, written from the WB stage (the MW step).
    always_ff @(posedge clk) begin
        if (wbs_valid_q && !wbs_ill_q) begin
            mem_q[wbs_addr_q] <= wbs_z_q;
        end
    end

    // Output taps of the WB stage and the debug read port.
    always_comb begin
        out_valid = wbs_valid_q;
        out_z     = wbs_z_q;
        out_addr  = wbs_addr_q;
        out_c     = wbs_c_q;
        out_zero  = wbs_zero_q;
        out_ill   = wbs_ill_q;
        dbg_data  = mem_q[dbg_addr];
    end

endmodule
